muldiv_unit: RTL



---
 rtl/muldiv_unit.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV64M multiply/divide unit feeding the register-file
//               write port. Operands are converted to magnitudes on accept,
//               processed one bit per clock for XLEN clocks (radix-2 shift-add
//               or restoring divide), and then sign-corrected into a
//               registered result that is presented for one DONE cycle.
// Ports       : clock, reset_n (async, active low)
//               start, funct3, op_a, op_b, rd_in  - request (accepted in IDLE)
//               busy      - unit not idle
//               done      - one-cycle completion pulse
//               result    - final value, qualify with done
//               wr        - destination index of the last completion
//               reg_write - done and wr != 0
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      wr,
    output logic            reg_write
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(XLEN - 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            fn_q, fn_d;
    logic [4:0]            rd_q, rd_d;
    logic [4:0]            wr_q, wr_d;
    logic [XLEN-1:0]       opnd_q, opnd_d;    // |op_a| for multiply, |op_b| for divide
    logic [2*XLEN-1:0]     acc_q, acc_d;      // product, or dividend/quotient in low half
    logic [XLEN-1:0]       rem_q, rem_d;      // partial remainder (always < divisor)
    logic [XLEN-1:0]       opa_q, opa_d;      // raw op_a, returned as remainder on /0
    logic                  sa_q, sa_d;
    logic                  sb_q, sb_d;
    logic [XLEN-1:0]       result_q, result_d;
    logic                  done_q, done_d;
    logic                  regw_q, regw_d;

    // ---- operand conditioning at accept ------------------------------------
    logic            w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic [XLEN-1:0] w_a_mag, w_b_mag;

    assign w_a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                        (funct3 == 3'b100) || (funct3 == 3'b110);
    assign w_b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) ||
                        (funct3 == 3'b110);
    assign w_a_neg    = w_a_signed & op_a[XLEN-1];
    assign w_b_neg    = w_b_signed & op_b[XLEN-1];
    assign w_a_mag    = w_a_neg ? (~op_a + 1'b1) : op_a;
    assign w_b_mag    = w_b_neg ? (~op_b + 1'b1) : op_b;

    // ---- one multiply step: add multiplicand if LSB set, shift right -------
    logic [XLEN:0]     w_madd;
    logic [2*XLEN-1:0] w_mul_nx;

    assign w_madd   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign w_mul_nx = {w_madd, acc_q[XLEN-1:1]};

    // ---- one restoring-divide step -----------------------------------------
    logic [XLEN:0]   w_rsh, w_rdiff;
    logic            w_ge;
    logic [XLEN-1:0] w_rem_nx, w_quo_nx;

    assign w_rsh    = {rem_q, acc_q[XLEN-1]};
    assign w_ge     = (w_rsh >= {1'b0, opnd_q});
    assign w_rdiff  = w_rsh - {1'b0, opnd_q};
    // Remainder stays below the divisor, so the top bit is always zero here.
    assign w_rem_nx = w_ge ? w_rdiff[XLEN-1:0] : w_rsh[XLEN-1:0];
    assign w_quo_nx = {acc_q[XLEN-2:0], w_ge};

    // ---- sign fix-up on the final iteration --------------------------------
    logic              w_neg, w_bzero;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo_s, w_rem_s, w_final;

    assign w_neg   = sa_q ^ sb_q;
    assign w_bzero = (opnd_q == '0);
    assign w_prod  = w_neg ? (~w_mul_nx + 1'b1) : w_mul_nx;
    assign w_quo_s = w_neg ? (~w_quo_nx + 1'b1) : w_quo_nx;
    assign w_rem_s = sa_q  ? (~w_rem_nx + 1'b1) : w_rem_nx;

    always_comb begin
        w_final = '0;
        case (fn_q)
            3'b000:                 w_final = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_final = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_final = w_bzero ? '1 : w_quo_s;
            default:                w_final = w_bzero ? opa_q : w_rem_s;
        endcase
    end

    logic w_unused_bits;
    assign w_unused_bits = ^{w_rdiff[XLEN], w_rsh[XLEN]};

    // ---- next-state logic --------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fn_d     = fn_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        opa_d    = opa_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        result_d = result_q;
        done_d   = 1'b0;
        regw_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    fn_d    = funct3;
                    rd_d    = rd_in;
                    opa_d   = op_a;
                    sa_d    = w_a_neg;
                    sb_d    = w_b_neg;
                    rem_d   = '0;
                    opnd_d  = funct3[2] ? w_b_mag : w_a_mag;
                    acc_d   = {{XLEN{1'b0}}, (funct3[2] ? w_a_mag : w_b_mag)};
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (fn_q[2]) begin
                    acc_d = {acc_q[2*XLEN-1:XLEN], w_quo_nx};
                    rem_d = w_rem_nx;
                end else begin
                    acc_d = w_mul_nx;
                end
                if (cnt_q == c_LAST) begin
                    state_d  = S_DONE;
                    result_d = w_final;
                    wr_d     = rd_q;
                    done_d   = 1'b1;
                    regw_d   = (rd_q != 5'd0);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            fn_q     <= '0;
            rd_q     <= '0;
            wr_q     <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            opa_q    <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
            regw_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fn_q     <= fn_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            opa_q    <= opa_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            result_q <= result_d;
            done_q   <= done_d;
            regw_q   <= regw_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign reg_write = regw_q;
    assign result    = result_q;
    assign wr        = wr_q;

endmodule
`default_nettype wire
